// File: rtl/ara_dfx_axi_decoupler.sv
// AXI decoupler for the Ara VLSU reconfigurable partition: drains accepted bursts on request,
// then clamps both sides so the partition can be swapped without upsetting the crossbar.
package ara_dfx_axi_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } axi_resp_t;
endpackage

module ara_dfx_axi_decoupler #(
  parameter type         axi_req_t  = ara_dfx_axi_pkg::axi_req_t,
  parameter type         axi_resp_t = ara_dfx_axi_pkg::axi_resp_t,
  parameter int unsigned MaxTxns    = 8,
  localparam int unsigned CntW      = $clog2(MaxTxns + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  axi_req_t        slv_req_i,
  output axi_resp_t       slv_resp_o,
  output axi_req_t        mst_req_o,
  input  axi_resp_t       mst_resp_i,
  input  logic            decouple_req_i,
  output logic            decouple_ack_o,
  output logic [CntW-1:0] rd_pending_o,
  output logic [CntW-1:0] wr_pending_o
);

  typedef enum logic [1:0] {RUN, DRAIN, DECOUPLED} state_e;

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0] w_cnt_q, w_cnt_d;
  logic [CntW-1:0] w_early_q, w_early_d;

  logic ar_hs, rl_hs, aw_hs, b_hs, wl_hs, all_idle;

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    unique case (state_q)
      RUN: begin
        if (rd_cnt_q == MaxCnt) begin
          mst_req_o.ar_valid  = 1'b0;
          slv_resp_o.ar_ready = 1'b0;
        end
        if (wr_cnt_q == MaxCnt || w_cnt_q == MaxCnt) begin
          mst_req_o.aw_valid  = 1'b0;
          slv_resp_o.aw_ready = 1'b0;
        end
      end
      DRAIN: begin
        mst_req_o.ar_valid  = 1'b0;
        mst_req_o.aw_valid  = 1'b0;
        slv_resp_o.ar_ready = 1'b0;
        slv_resp_o.aw_ready = 1'b0;
        if (w_cnt_q == '0) begin
          mst_req_o.w_valid  = 1'b0;
          slv_resp_o.w_ready = 1'b0;
        end
      end
      default: begin
        mst_req_o.ar_valid  = 1'b0;
        mst_req_o.aw_valid  = 1'b0;
        mst_req_o.w_valid   = 1'b0;
        mst_req_o.b_ready   = 1'b1;
        mst_req_o.r_ready   = 1'b1;
        slv_resp_o.ar_ready = 1'b0;
        slv_resp_o.aw_ready = 1'b0;
        slv_resp_o.w_ready  = 1'b0;
        slv_resp_o.b_valid  = 1'b0;
        slv_resp_o.r_valid  = 1'b0;
      end
    endcase
  end

  assign ar_hs = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign rl_hs = mst_resp_i.r_valid & mst_req_o.r_ready & mst_resp_i.r.last;
  assign aw_hs = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign b_hs  = mst_resp_i.b_valid & mst_req_o.b_ready;
  assign wl_hs = mst_req_o.w_valid & mst_resp_i.w_ready & mst_req_o.w.last;

  assign all_idle = (rd_cnt_q == '0) && (wr_cnt_q == '0) && (w_cnt_q == '0);

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    w_cnt_d   = w_cnt_q;
    w_early_d = w_early_q;

    // Absorbed responses while decoupled must not underflow the counters.
    if (ar_hs && !rl_hs && rd_cnt_q != MaxCnt) rd_cnt_d = rd_cnt_q + 1'b1;
    else if (rl_hs && !ar_hs && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 1'b1;

    if (aw_hs && !b_hs && wr_cnt_q != MaxCnt) wr_cnt_d = wr_cnt_q + 1'b1;
    else if (b_hs && !aw_hs && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 1'b1;

    // A W burst completed ahead of its AW is banked and cancels that AW on arrival.
    if (aw_hs && !wl_hs) begin
      if (w_early_q != '0) w_early_d = w_early_q - 1'b1;
      else if (w_cnt_q != MaxCnt) w_cnt_d = w_cnt_q + 1'b1;
    end else if (wl_hs && !aw_hs) begin
      if (w_cnt_q != '0) w_cnt_d = w_cnt_q - 1'b1;
      else if (w_early_q != MaxCnt) w_early_d = w_early_q + 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      RUN:       if (decouple_req_i) state_d = DRAIN;
      DRAIN:     if (all_idle) state_d = decouple_req_i ? DECOUPLED : RUN;
      DECOUPLED: if (!decouple_req_i) state_d = RUN;
      default:   state_d = RUN;
    endcase
    ack_d = (state_d == DECOUPLED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      ack_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      w_cnt_q   <= '0;
      w_early_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      w_cnt_q   <= w_cnt_d;
      w_early_q <= w_early_d;
    end
  end

  assign decouple_ack_o = ack_q;
  assign rd_pending_o   = rd_cnt_q;
  assign wr_pending_o   = wr_cnt_q;

endmodule

// File: tb/tb_ara_dfx_axi_decoupler.sv
// Directed bench for ara_dfx_axi_decoupler: passthrough, drain, clamp, release, abort, reset
// on a MaxTxns=8 instance, and saturation on a MaxTxns=2 instance.
module tb_ara_dfx_axi_decoupler;
  import ara_dfx_axi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  axi_req_t  a_slv_req, a_mst_req;
  axi_resp_t a_slv_rsp, a_mst_rsp;
  logic      a_dec, a_ack;
  logic [3:0] a_rd, a_wr;

  axi_req_t  b_slv_req, b_mst_req;
  axi_resp_t b_slv_rsp, b_mst_rsp;
  logic      b_dec, b_ack;
  logic [1:0] b_rd, b_wr;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  ara_dfx_axi_decoupler #(.MaxTxns(8)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(a_slv_req), .slv_resp_o(a_slv_rsp),
    .mst_req_o(a_mst_req), .mst_resp_i(a_mst_rsp),
    .decouple_req_i(a_dec), .decouple_ack_o(a_ack),
    .rd_pending_o(a_rd), .wr_pending_o(a_wr)
  );

  ara_dfx_axi_decoupler #(.MaxTxns(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(b_slv_req), .slv_resp_o(b_slv_rsp),
    .mst_req_o(b_mst_req), .mst_resp_i(b_mst_rsp),
    .decouple_req_i(b_dec), .decouple_ack_o(b_ack),
    .rd_pending_o(b_rd), .wr_pending_o(b_wr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_a();
    a_slv_req = '0;
    a_mst_rsp = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_dec = 1'b0;
    b_dec = 1'b0;
    clear_a();
    b_slv_req = '0;
    b_mst_rsp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", a_ack, 0);
    chk("reset_rd", a_rd, 0);
    chk("reset_wr", a_wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Passthrough: 3 reads of len 3
    for (int i = 0; i < 3; i++) begin
      a_slv_req.ar_valid = 1'b1;
      a_slv_req.ar.id    = 4'(i);
      a_slv_req.ar.addr  = 32'h1000 + 32'(i) * 32'h40;
      a_slv_req.ar.len   = 8'd3;
      a_mst_rsp.ar_ready = 1'b1;
      settle();
      chk("pt_ar_valid", a_mst_req.ar_valid, 1);
      chk("pt_ar_ready", a_slv_rsp.ar_ready, 1);
      chk("pt_ar_addr", a_mst_req.ar.addr, 64'h1000 + 64'(i) * 64'h40);
      chk("pt_ar_len", a_mst_req.ar.len, 3);
      tick();
      chk("pt_rd_cnt", a_rd, 64'(i + 1));
    end
    clear_a();

    // Passthrough: 2 single-beat writes, AW and W together
    for (int j = 0; j < 2; j++) begin
      a_slv_req.aw_valid = 1'b1;
      a_slv_req.aw.id    = 4'(j + 8);
      a_slv_req.aw.addr  = 32'h2000 + 32'(j) * 32'h100;
      a_slv_req.w_valid  = 1'b1;
      a_slv_req.w.data   = 64'hA5A5_0000_0000_0000 | 64'(j);
      a_slv_req.w.strb   = 8'hFF;
      a_slv_req.w.last   = 1'b1;
      a_mst_rsp.aw_ready = 1'b1;
      a_mst_rsp.w_ready  = 1'b1;
      settle();
      chk("pt_aw_addr", a_mst_req.aw.addr, 64'h2000 + 64'(j) * 64'h100);
      chk("pt_w_data", a_mst_req.w.data, 64'hA5A5_0000_0000_0000 | 64'(j));
      chk("pt_w_ready", a_slv_rsp.w_ready, 1);
      tick();
      chk("pt_wr_cnt", a_wr, 64'(j + 1));
    end
    clear_a();
    chk("pt_rd_peak", a_rd, 3);
    chk("pt_ack0", a_ack, 0);

    for (int j = 0; j < 2; j++) begin
      a_mst_rsp.b_valid = 1'b1;
      a_mst_rsp.b.id    = 4'(j + 8);
      a_slv_req.b_ready = 1'b1;
      settle();
      chk("pt_b_valid", a_slv_rsp.b_valid, 1);
      chk("pt_b_id", a_slv_rsp.b.id, 64'(j + 8));
      tick();
    end
    clear_a();
    chk("pt_wr_zero", a_wr, 0);

    for (int k = 0; k < 12; k++) begin
      a_mst_rsp.r_valid = 1'b1;
      a_mst_rsp.r.data  = 64'(k) + 64'h100;
      a_mst_rsp.r.last  = ((k % 4) == 3);
      a_slv_req.r_ready = 1'b1;
      settle();
      chk("pt_r_data", a_slv_rsp.r.data, 64'(k) + 64'h100);
      tick();
      if (k == 3) chk("pt_rd_after1", a_rd, 2);
    end
    clear_a();
    chk("pt_rd_zero", a_rd, 0);
    chk("pt_ack_end", a_ack, 0);

    // Drain: 2 reads and 1 write (AW only) outstanding
    a_slv_req.ar_valid = 1'b1;
    a_mst_rsp.ar_ready = 1'b1;
    tick();
    tick();
    clear_a();
    a_slv_req.aw_valid = 1'b1;
    a_mst_rsp.aw_ready = 1'b1;
    tick();
    clear_a();
    chk("dr_rd_pre", a_rd, 2);
    chk("dr_wr_pre", a_wr, 1);
    a_dec = 1'b1;
    tick();
    a_slv_req.ar_valid = 1'b1;
    a_mst_rsp.ar_ready = 1'b1;
    settle();
    chk("dr_ar_blk_mst", a_mst_req.ar_valid, 0);
    chk("dr_ar_blk_slv", a_slv_rsp.ar_ready, 0);
    clear_a();
    a_slv_req.w_valid = 1'b1;
    a_slv_req.w.last  = 1'b1;
    a_slv_req.w.data  = 64'hDEAD_BEEF;
    a_mst_rsp.w_ready = 1'b1;
    settle();
    chk("dr_w_fwd", a_mst_req.w_valid, 1);
    chk("dr_w_data", a_mst_req.w.data, 64'hDEAD_BEEF);
    tick();
    settle();
    chk("dr_w_blk", a_mst_req.w_valid, 0);
    chk("dr_w_rdy_blk", a_slv_rsp.w_ready, 0);
    clear_a();
    a_mst_rsp.b_valid = 1'b1;
    a_slv_req.b_ready = 1'b1;
    settle();
    chk("dr_b_pass", a_slv_rsp.b_valid, 1);
    tick();
    clear_a();
    chk("dr_wr_zero", a_wr, 0);
    a_mst_rsp.r_valid = 1'b1;
    a_mst_rsp.r.last  = 1'b1;
    a_slv_req.r_ready = 1'b1;
    tick();
    chk("dr_rd_one", a_rd, 1);
    chk("dr_ack_mid", a_ack, 0);
    tick();
    clear_a();
    chk("dr_rd_zero", a_rd, 0);
    chk("dr_ack_zero_cyc", a_ack, 0);
    tick();
    chk("dr_ack_rise", a_ack, 1);

    // Clamp while decoupled
    a_slv_req.aw_valid = 1'b1;
    a_slv_req.ar_valid = 1'b1;
    a_slv_req.w_valid  = 1'b1;
    a_slv_req.aw.addr  = $urandom;
    a_slv_req.ar.addr  = $urandom;
    a_slv_req.w.data   = {$urandom, $urandom};
    a_slv_req.w.last   = 1'b1;
    a_mst_rsp.aw_ready = 1'b1;
    a_mst_rsp.ar_ready = 1'b1;
    a_mst_rsp.w_ready  = 1'b1;
    a_mst_rsp.r_valid  = 1'b1;
    a_mst_rsp.r.last   = 1'b1;
    a_mst_rsp.b_valid  = 1'b1;
    settle();
    chk("cl_aw_valid", a_mst_req.aw_valid, 0);
    chk("cl_ar_valid", a_mst_req.ar_valid, 0);
    chk("cl_w_valid", a_mst_req.w_valid, 0);
    chk("cl_slv_rdy", {a_slv_rsp.aw_ready, a_slv_rsp.ar_ready, a_slv_rsp.w_ready}, 0);
    chk("cl_slv_rsp", {a_slv_rsp.b_valid, a_slv_rsp.r_valid}, 0);
    chk("cl_absorb", {a_mst_req.b_ready, a_mst_req.r_ready}, 3);
    tick();
    chk("cl_rd_hold", a_rd, 0);
    chk("cl_wr_hold", a_wr, 0);
    chk("cl_ack_hold", a_ack, 1);
    clear_a();

    // Release
    a_dec = 1'b0;
    tick();
    chk("rl_ack", a_ack, 0);
    a_slv_req.ar_valid = 1'b1;
    a_mst_rsp.ar_ready = 1'b1;
    settle();
    chk("rl_ar_valid", a_mst_req.ar_valid, 1);
    chk("rl_ar_ready", a_slv_rsp.ar_ready, 1);
    tick();
    clear_a();
    chk("rl_rd", a_rd, 1);
    a_mst_rsp.r_valid = 1'b1;
    a_mst_rsp.r.last  = 1'b1;
    a_slv_req.r_ready = 1'b1;
    tick();
    clear_a();
    chk("rl_rd_zero", a_rd, 0);

    // Abort attempt: request dropped mid-drain
    a_slv_req.ar_valid = 1'b1;
    a_mst_rsp.ar_ready = 1'b1;
    tick();
    clear_a();
    a_dec = 1'b1;
    tick();
    a_dec = 1'b0;
    tick();
    a_slv_req.ar_valid = 1'b1;
    settle();
    chk("ab_still_drain", a_mst_req.ar_valid, 0);
    clear_a();
    a_mst_rsp.r_valid = 1'b1;
    a_mst_rsp.r.last  = 1'b1;
    a_slv_req.r_ready = 1'b1;
    tick();
    clear_a();
    chk("ab_rd_zero", a_rd, 0);
    chk("ab_ack_a", a_ack, 0);
    tick();
    chk("ab_ack_b", a_ack, 0);
    a_slv_req.ar_valid = 1'b1;
    settle();
    chk("ab_run_ar", a_mst_req.ar_valid, 1);
    clear_a();

    // Asynchronous reset mid-drain
    a_slv_req.ar_valid = 1'b1;
    a_mst_rsp.ar_ready = 1'b1;
    tick();
    clear_a();
    a_dec = 1'b1;
    tick();
    a_slv_req.ar_valid = 1'b1;
    settle();
    chk("rs_in_drain", a_mst_req.ar_valid, 0);
    chk("rs_rd_pre", a_rd, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_rd_async", a_rd, 0);
    chk("rs_ack_async", a_ack, 0);
    chk("rs_run_async", a_mst_req.ar_valid, 1);
    a_dec = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    settle();
    chk("rs_run_after", a_mst_req.ar_valid, 1);
    clear_a();

    // Saturation and simultaneity on the MaxTxns=2 instance
    b_slv_req.ar_valid = 1'b1;
    b_mst_rsp.ar_ready = 1'b1;
    tick();
    tick();
    chk("st_rd_two", b_rd, 2);
    settle();
    chk("st_ar_stall_mst", b_mst_req.ar_valid, 0);
    chk("st_ar_stall_slv", b_slv_rsp.ar_ready, 0);
    b_mst_rsp.r_valid = 1'b1;
    b_mst_rsp.r.last  = 1'b1;
    b_slv_req.r_ready = 1'b1;
    tick();
    chk("st_rd_dec", b_rd, 1);
    settle();
    chk("st_ar_open", b_mst_req.ar_valid, 1);
    tick();
    chk("st_rd_same", b_rd, 1);
    b_mst_rsp.r_valid = 1'b0;
    tick();
    chk("st_rd_back2", b_rd, 2);
    b_slv_req = '0;
    b_mst_rsp = '0;
    b_slv_req.aw_valid = 1'b1;
    b_mst_rsp.aw_ready = 1'b1;
    tick();
    tick();
    chk("st_wr_two", b_wr, 2);
    settle();
    chk("st_aw_stall", b_mst_req.aw_valid, 0);
    chk("st_aw_rdy", b_slv_rsp.aw_ready, 0);
    tick();
    chk("st_wr_hold", b_wr, 2);
    b_slv_req = '0;
    b_mst_rsp = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
